// File: rtl/buffer_serializer.sv
// buffer_serializer: loads a parallel word and shifts it out LSB first, one strobed bit per
// cycle, with a per-bit RAM address made of the bit index and a word sequence number.
// Optional build macro SERIALIZER_PARITY_EN adds one even-parity cycle after the last data bit.
module buffer_serializer #(
   parameter int unsigned counter_size = 4,
   parameter int unsigned buffer_size  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load_valid,
   input  logic [buffer_size-1:0]    load_data,
   output logic                      load_ready,
   input  logic                      halt,
   output logic                      txda,
   output logic                      oeenable,
   output logic [counter_size*2:0]   ramadrs,
   output logic                      done,
   output logic                      par_valid
);

   // The bit index must address every bit of the word exactly.
   if (buffer_size != (1 << counter_size)) begin : g_bad_param
      $error("buffer_size must equal 2**counter_size");
   end

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StDone = 2'd2, StParity = 2'd3} state_e;
`else
   typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StDone = 2'd2} state_e;
`endif

   localparam logic [counter_size-1:0] IndexOne  = 1;
   localparam logic [counter_size-1:0] IndexLast = '1;
   localparam logic [counter_size:0]   SeqOne    = 1;

   state_e                    state_q;
   logic [counter_size-1:0]   index_q;
   logic [counter_size:0]     seq_q;
   logic [buffer_size-1:0]    shadow_q;
   logic [counter_size*2:0]   adrs_q;   // address of the last strobed bit
   logic                      txda_q;   // last strobed data bit, shown while halted
   logic                      strobe;

   // Sequencer: capture, per-bit advance, parity/done steps and sequence numbering.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         index_q  <= '0;
         seq_q    <= '0;
         shadow_q <= '0;
         adrs_q   <= '0;
         txda_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (load_valid) begin
                  shadow_q <= load_data;
                  index_q  <= '0;
                  txda_q   <= 1'b0;
                  state_q  <= StShift;
               end
            end
            StShift: begin
               if (!halt) begin
                  adrs_q  <= {index_q, seq_q};
                  txda_q  <= shadow_q[index_q];
                  index_q <= index_q + IndexOne;
                  if (index_q == IndexLast) begin
`ifdef SERIALIZER_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StDone;
`endif
                  end
               end
            end
`ifdef SERIALIZER_PARITY_EN
            StParity: state_q <= StDone;
`endif
            StDone: begin
               seq_q   <= seq_q + SeqOne;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs: decoded from state; halt gates the strobe within the same cycle.
   always_comb begin
      strobe     = (state_q == StShift) && !halt;
      load_ready = (state_q == StIdle);
      done       = (state_q == StDone);
      oeenable   = !strobe;
      ramadrs    = strobe ? {index_q, seq_q} : adrs_q;
      txda       = 1'b0;
      if (state_q == StShift) begin
         txda = strobe ? shadow_q[index_q] : txda_q;
      end
`ifdef SERIALIZER_PARITY_EN
      par_valid = (state_q == StParity);
      if (state_q == StParity) begin
         txda = ^shadow_q;
      end
`else
      par_valid = 1'b0;
`endif
   end

endmodule

// File: doc/buffer_serializer.md
BUFFER_SERIALIZER -- requirements
Module: buffer_serializer

Interface
REQ-001 Parameter counter_size, default 4: width of the bit-index field.
REQ-002 Parameter buffer_size, default 16: word width; SHALL equal 2**counter_size.
REQ-003 clock  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  parallel word offered on load_data.
REQ-006 load_data  input  buffer_size  word to serialize.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 halt  input  1  stalls shifting while high.
REQ-009 txda  output  1  serial data bit.
REQ-010 oeenable  output  1  active-low bit strobe; 0 means txda and ramadrs are valid this cycle.
REQ-011 ramadrs  output  counter_size*2+1  [counter_size*2:counter_size+1] = bit index; [counter_size:0] = word sequence number.
REQ-012 done  output  1  one-cycle pulse after a word completes.
REQ-013 par_valid  output  1  parity-cycle flag (see Configuration).

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE, plus PARITY when the macro is defined.
REQ-015 IDLE: load_ready=1, oeenable=1, txda=0, done=0; load_valid=1 captures load_data into a shadow register and moves to SHIFT.
REQ-016 SHIFT, halt=0: oeenable=0, txda=shadow[index], bit-index field=index; index increments by 1 per cycle, LSB first.
REQ-017 SHIFT, halt=1: oeenable=1; index, txda and the shadow register hold.
REQ-018 Halt SHALL only affect SHIFT; it SHALL be ignored in IDLE, DONE and PARITY.
REQ-019 After the strobed cycle with index = buffer_size-1, the next state SHALL be DONE, or PARITY when the macro is defined.
REQ-020 DONE lasts one cycle: done=1, oeenable=1, sequence number increments modulo 2**(counter_size+1) (31 wraps to 0), then IDLE.
REQ-021 load_ready SHALL be 0 in every state except IDLE; load_valid outside IDLE SHALL be ignored and nothing captured.
REQ-022 Latency: load accepted at edge N; first strobe in cycle N+1; last strobe in cycle N+buffer_size when not halted; done in cycle N+buffer_size+1.
REQ-023 Each halted cycle SHALL delay done by exactly one cycle.
REQ-024 Back-to-back operation: load_valid held high SHALL give one idle cycle between words.
REQ-025 ramadrs SHALL hold its last value while oeenable=1, except at reset.

Reset
REQ-026 reset=1 SHALL force, at the next edge: state IDLE, load_ready=1, oeenable=1, txda=0, done=0, par_valid=0, ramadrs=0, shadow=0.
REQ-027 Reset SHALL override every other input, including load_valid and halt.
REQ-028 Reset mid-word SHALL abort the transfer with no done pulse, and SHALL clear the sequence number to 0.

Configuration
REQ-029 The macro SERIALIZER_PARITY_EN SHALL be the only configuration option.
REQ-030 With the macro defined, one PARITY cycle SHALL follow the last data bit: txda = even parity (XOR of the word), par_valid=1, oeenable=1, then DONE; done moves to cycle N+buffer_size+2.
REQ-031 Without the macro, the PARITY state SHALL not exist and par_valid SHALL be tied to 0.

Verification
REQ-032 Reset, then load 16'hA5C3 -> cycles 1-16 give oeenable=0, index 0..15, txda = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done in cycle 17; seq 0->1.
REQ-033 halt=1 for 3 cycles while index=5 -> oeenable=1 and index holds 5 for those 3 cycles; done arrives 3 cycles later (cycle 20).
REQ-034 load_valid pulsed at index 8 with 16'hFFFF -> ignored; the transfer completes with the original word; load_ready=0 until IDLE.
REQ-035 reset asserted at index 10 -> next cycle IDLE, ramadrs=0, oeenable=1, no done; a fresh load of 16'h0001 then serializes with seq=0.
REQ-036 Run 33 consecutive words -> sequence number runs 0..31, wraps to 0, and ends at 1.
REQ-037 With SERIALIZER_PARITY_EN, load 16'h0007 -> parity cycle 17 gives txda=1, par_valid=1; done in cycle 18. Without the macro, par_valid stays 0.
